// File: rtl/dds_spi_pkg.sv
// rtl/dds_spi_pkg.sv - shared widths, register map and FSM state type for the DDS SPI link
package dds_spi_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int SPI_ADDR_W = 4;
    localparam int SPI_DATA_W = 28;

    localparam logic [SPI_ADDR_W-1:0] ADDR_MODE   = 4'd0;
    localparam logic [SPI_ADDR_W-1:0] ADDR_FREQ0  = 4'd1;
    localparam logic [SPI_ADDR_W-1:0] ADDR_FREQ1  = 4'd2;
    localparam logic [SPI_ADDR_W-1:0] ADDR_PHASE0 = 4'd3;
    localparam logic [SPI_ADDR_W-1:0] ADDR_PHASE1 = 4'd4;
    localparam logic [SPI_ADDR_W-1:0] ADDR_GAIN   = 4'd5;
    localparam logic [SPI_ADDR_W-1:0] ADDR_OFFSET = 4'd6;

    localparam int FREQ_W   = 28;
    localparam int PHASE_W  = 12;
    localparam int MODE_W   = 2;
    localparam int GAIN_W   = 8;
    localparam int OFFSET_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCK_HIGH,
        ST_SCK_LOW,
        ST_GAP
    } spi_state_t;

    function automatic logic [SPI_WORD_W-1:0] spi_pack_word(
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        return {addr, data};
    endfunction

endpackage

// File: rtl/spi_master_writer_if.sv
// rtl/spi_master_writer_if.sv - command handshake and SPI pin bundle for spi_master_writer
interface spi_master_writer_if;
    import dds_spi_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SPI_ADDR_W-1:0] cmd_addr;
    logic [SPI_DATA_W-1:0] cmd_data;
    logic                  spi_clock;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_addr, cmd_data,
        input  cmd_ready, spi_clock, spi_cs_n, spi_mosi, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data,
        output cmd_ready, spi_clock, spi_cs_n, spi_mosi, busy, done
    );

endinterface

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - loadable down-counter; tick on the last cycle of each phase
module spi_half_period_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_restart,
    input  logic [CNT_W-1:0] i_load,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    // Loading N-1 on entry makes the phase last exactly N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= i_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_master_writer.sv
// rtl/spi_master_writer.sv - SPI mode-0 write-only master, 32-bit {addr,data} words MSB first
module spi_master_writer
    import dds_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_master_writer_if.slave  bus
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    spi_state_t            r_state;
    spi_state_t            w_state_nxt;
    logic [SPI_WORD_W-1:0] r_shift;
    logic [4:0]            r_bit_cnt;

    logic r_sclk, r_cs_n, r_mosi, r_ready, r_busy, r_done;
    logic w_sclk_nxt, w_cs_n_nxt, w_mosi_nxt, w_ready_nxt, w_busy_nxt, w_done_nxt;

    logic       w_tick;
    logic       w_restart;
    logic [7:0] w_load;
    logic       w_accept;
    logic       w_last_bit;
    logic       w_shift_adv;

    assign w_accept    = (r_state == ST_IDLE) && bus.cmd_valid && r_ready;
    assign w_last_bit  = (r_bit_cnt == 5'd0);
    assign w_shift_adv = (r_state == ST_SCK_HIGH) && (w_state_nxt == ST_SCK_LOW) && !w_last_bit;
    assign w_restart   = (w_state_nxt != r_state);
    assign w_load      = (w_state_nxt == ST_GAP) ? GAP_LOAD : DIV_LOAD;

    spi_half_period_timer #(.CNT_W(8)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .i_load    (w_load),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_state_nxt = ST_SETUP;
            ST_SETUP:    if (w_tick)   w_state_nxt = ST_SCK_HIGH;
            ST_SCK_HIGH: if (w_tick)   w_state_nxt = ST_SCK_LOW;
            ST_SCK_LOW:  if (w_tick)   w_state_nxt = w_last_bit ? ST_GAP : ST_SCK_HIGH;
            ST_GAP:      if (w_tick)   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every output is a flop.
    always_comb begin
        w_sclk_nxt  = (w_state_nxt == ST_SCK_HIGH);
        w_cs_n_nxt  = !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SCK_HIGH) ||
                        (w_state_nxt == ST_SCK_LOW));
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_done_nxt  = (r_state == ST_SCK_LOW) && (w_state_nxt == ST_GAP);
        w_mosi_nxt  = r_mosi;
        if (w_accept) begin
            w_mosi_nxt = bus.cmd_addr[SPI_ADDR_W-1];
        end else if (w_shift_adv) begin
            w_mosi_nxt = r_shift[SPI_WORD_W-2];
        end else if (w_state_nxt == ST_IDLE) begin
            w_mosi_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= 5'd0;
        end else begin
            r_sclk  <= w_sclk_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_mosi  <= w_mosi_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_shift   <= spi_pack_word(bus.cmd_addr, bus.cmd_data);
                r_bit_cnt <= 5'd31;
            end else if (w_shift_adv) begin
                r_shift <= {r_shift[SPI_WORD_W-2:0], 1'b0};
            end
            if ((r_state == ST_SCK_LOW) && w_tick && !w_last_bit) begin
                r_bit_cnt <= r_bit_cnt - 5'd1;
            end
        end
    end

    assign bus.spi_clock = r_sclk;
    assign bus.spi_cs_n  = r_cs_n;
    assign bus.spi_mosi  = r_mosi;
    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
